// File: rtl/vector_collect.sv
// Serial-to-parallel collector: packs BITS-wide elements into WIDTH-element vectors,
// padding short vectors (in_last) by duplicating the closing element.
module vector_collect #(
  parameter int unsigned BITS     = 16,
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned CNT_BITS = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     a,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS-1:0]     vector_c [WIDTH],
  output logic [CNT_BITS-1:0] out_count
);

  localparam int unsigned IdxBits = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {StFill, StHold} state_e;

  state_e              state_q;
  logic [IdxBits-1:0]  idx_q;
  logic [BITS-1:0]     asm_q [WIDTH];
  logic [BITS-1:0]     asm_d [WIDTH];
  logic [CNT_BITS-1:0] asm_count_q;
  logic [CNT_BITS-1:0] done_count;
  logic                accept;
  logic                last_slot;
  logic                complete;
  logic                out_free;
  logic                release_hold;

  assign in_ready     = (state_q == StFill) && !rst;
  assign accept       = in_valid && in_ready;
  assign last_slot    = (idx_q == IdxBits'(WIDTH - 1));
  assign complete     = accept && (last_slot || in_last);
  assign out_free     = !out_valid || out_ready;
  assign release_hold = (state_q == StHold) && out_valid && out_ready;
  assign done_count   = CNT_BITS'(idx_q) + CNT_BITS'(1);

  // Assembly contents after this cycle's write; slots past idx get the closing
  // element when the vector ends early.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && ((IdxBits'(i) == idx_q) || (complete && (IdxBits'(i) > idx_q)))) begin
        asm_d[i] = a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      idx_q       <= '0;
      out_valid   <= 1'b0;
      out_count   <= '0;
      asm_count_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        vector_c[i] <= '0;
        asm_q[i]    <= '0;
      end
    end else begin
      if (accept) begin
        idx_q <= complete ? '0 : idx_q + 1'b1;
        asm_q <= asm_d;
      end
      if (complete && out_free) begin
        vector_c  <= asm_d;
        out_count <= done_count;
        out_valid <= 1'b1;
      end else if (complete) begin
        // Output still occupied: park the finished vector in the assembly register.
        asm_count_q <= done_count;
        state_q     <= StHold;
      end else if (release_hold) begin
        vector_c  <= asm_q;
        out_count <= asm_count_q;
        out_valid <= 1'b1;
        state_q   <= StFill;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vector_collect.sv
// Directed self-checking bench for vector_collect with WIDTH=3, BITS=16.
module tb_vector_collect;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] vector_c [3];
  logic [1:0]  out_count;

  int n_vec;
  int n_err;

  vector_collect #(
    .BITS (16),
    .WIDTH(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .vector_c (vector_c),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'hdead; in_last = 1'b0; out_ready = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_count !== 2'd0) begin
      n_err++; $display("FAIL reset_out: got valid=%b cnt=%0d want 0 0", out_valid, out_count);
    end
    n_vec++;
    if ({vector_c[0], vector_c[1], vector_c[2]} !== 48'h0) begin
      n_err++; $display("FAIL reset_vec: got %h want 0", {vector_c[0], vector_c[1], vector_c[2]});
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL post_reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_full();
    logic [15:0] el [3];
    el[0] = 16'h3c00; el[1] = 16'h4000; el[2] = 16'h4200;
    out_ready = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = el[i];
      tick();
      n_vec++;
      if (out_valid !== (i == 2)) begin
        n_err++; $display("FAIL full_valid[%0d]: got %b want %b", i, out_valid, (i == 2));
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if ({vector_c[0], vector_c[1], vector_c[2]} !== 48'h3c00_4000_4200 || out_count !== 2'd3) begin
      n_err++; $display("FAIL full_vec: got %h cnt=%0d want 3c0040004200 cnt=3",
                        {vector_c[0], vector_c[1], vector_c[2]}, out_count);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL full_one_cycle: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_short();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h4400; in_last = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_count !== 2'd1 ||
        {vector_c[0], vector_c[1], vector_c[2]} !== 48'h4400_4400_4400) begin
      n_err++; $display("FAIL short1: got v=%b %h cnt=%0d want 1 440044004400 cnt=1",
                        out_valid, {vector_c[0], vector_c[1], vector_c[2]}, out_count);
    end
    a = 16'h3c00; in_last = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL short_mid_valid: got %b want 0", out_valid);
    end
    a = 16'h4000; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_count !== 2'd2 ||
        {vector_c[0], vector_c[1], vector_c[2]} !== 48'h3c00_4000_4000) begin
      n_err++; $display("FAIL short2: got v=%b %h cnt=%0d want 1 3c0040004000 cnt=2",
                        out_valid, {vector_c[0], vector_c[1], vector_c[2]}, out_count);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_last = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; a = 16'(i);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      if (i >= 3) begin
        n_vec++;
        if (out_valid !== 1'b1 || {vector_c[0], vector_c[1], vector_c[2]} !== 48'h0001_0002_0003) begin
          n_err++; $display("FAIL bp_hold_first[%0d]: got v=%b %h want 1 000100020003",
                            i, out_valid, {vector_c[0], vector_c[1], vector_c[2]});
        end
      end
    end
    // Element 7 offered while held: must be refused.
    a = 16'h0007;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_count !== 2'd3 ||
        {vector_c[0], vector_c[1], vector_c[2]} !== 48'h0004_0005_0006) begin
      n_err++; $display("FAIL bp_release: got v=%b rdy=%b %h cnt=%0d want 1 1 000400050006 3",
                        out_valid, in_ready, {vector_c[0], vector_c[1], vector_c[2]}, out_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h0010 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || {vector_c[0], vector_c[1], vector_c[2]} !== 48'h0010_0011_0012) begin
      n_err++; $display("FAIL bp_after: got v=%b %h want 1 001000110012",
                        out_valid, {vector_c[0], vector_c[1], vector_c[2]});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int delivered;
    logic [47:0] exp;
    delivered = 0;
    out_ready = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; a = 16'h0020 + 16'(i);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== ((i % 3) == 2)) begin
        n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, ((i % 3) == 2));
      end
      if ((i % 3) == 2) begin
        exp = {16'h0020 + 16'(i - 2), 16'h0020 + 16'(i - 1), 16'h0020 + 16'(i)};
        if (out_valid === 1'b1) delivered++;
        n_vec++;
        if ({vector_c[0], vector_c[1], vector_c[2]} !== exp) begin
          n_err++; $display("FAIL b2b_vec[%0d]: got %h want %h",
                            i, {vector_c[0], vector_c[1], vector_c[2]}, exp);
        end
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (delivered != 3) begin
      n_err++; $display("FAIL b2b_count: got %0d want 3", delivered);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 16'h00a0 + 16'(i);
      tick();
    end
    rst = 1'b1; a = 16'h00ff;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL rstmid_ready: got %b want 0", in_ready);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || out_count !== 2'd0 || {vector_c[0], vector_c[1], vector_c[2]} !== 48'h0) begin
      n_err++; $display("FAIL rstmid_out: got v=%b %h cnt=%0d want 0 0 0",
                        out_valid, {vector_c[0], vector_c[1], vector_c[2]}, out_count);
    end
    // Fill to HOLD under back-pressure, then reset again.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = 16'h00b0 + 16'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_count !== 2'd0 || in_ready !== 1'b1 ||
        {vector_c[0], vector_c[1], vector_c[2]} !== 48'h0) begin
      n_err++; $display("FAIL rsthold_out: got v=%b rdy=%b %h cnt=%0d want 0 1 0 0",
                        out_valid, in_ready, {vector_c[0], vector_c[1], vector_c[2]}, out_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h00c0 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_count !== 2'd3 ||
        {vector_c[0], vector_c[1], vector_c[2]} !== 48'h00c0_00c1_00c2) begin
      n_err++; $display("FAIL rst_fresh: got v=%b %h cnt=%0d want 1 00c000c100c2 3",
                        out_valid, {vector_c[0], vector_c[1], vector_c[2]}, out_count);
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    test_reset();
    test_full();
    test_short();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
